// File: rtl/package_settings_v2.sv
// Shared settings for the trapezoidal filter chain: ADC sample width,
// controller state encoding and default sequencing constants.
package package_settings_v2;

  localparam int SIZE_ADC_DATA = 16;

  localparam int DEF_SETTLE_CYCLES  = 32;
  localparam int DEF_PEAK_WINDOW    = 16;
  localparam int DEF_HOLDOFF_CYCLES = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ARMED,
    PEAK,
    REPORT,
    HOLDOFF
  } ctrl_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/timestamp_cnt.sv
// Free-running timestamp, +1 per clk, wraps modulo 2^TS_WIDTH.
// Registered output, 0 after reset; no backpressure.
module timestamp_cnt #(
  parameter int TS_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  output logic [TS_WIDTH-1:0] ts
);

  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] ts_d;

  always_comb ts_d = ts_q + TS_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  assign ts = ts_q;

endmodule

// File: rtl/trap_event_ctrl.sv
// Filter reset sequencing, threshold trigger, windowed peak search and event hand-off.
// Event registered on the last window sample; held until ev_ready, then dead-time holdoff.
module trap_event_ctrl
  import package_settings_v2::*;
#(
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int PEAK_WINDOW    = DEF_PEAK_WINDOW,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int TS_WIDTH       = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic signed [SIZE_ADC_DATA-1:0] threshold,
  input  logic signed [SIZE_ADC_DATA-1:0] filt_data,
  output logic                            filt_rst_n,
  output logic                            ev_valid,
  input  logic                            ev_ready,
  output logic signed [SIZE_ADC_DATA-1:0] ev_amp,
  output logic [TS_WIDTH-1:0]             ev_time,
  output logic                            ev_pileup,
  output logic [7:0]                      drop_cnt,
  output logic                            busy
);

  localparam int CNT_W = $clog2(max3(SETTLE_CYCLES, PEAK_WINDOW, HOLDOFF_CYCLES) + 1);

  logic [TS_WIDTH-1:0] ts;

  timestamp_cnt #(.TS_WIDTH(TS_WIDTH)) u_ts (
    .clk   (clk),
    .reset (reset),
    .ts    (ts)
  );

  ctrl_state_t                     state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic signed [SIZE_ADC_DATA-1:0] peak_q, peak_d;
  logic [TS_WIDTH-1:0]             peak_time_q, peak_time_d;
  logic                            below_q, below_d;
  logic                            pileup_q, pileup_d;
  logic                            prev_above_q, prev_above_d;
  logic [7:0]                      drop_cnt_q, drop_cnt_d;
  logic                            ev_valid_q, ev_valid_d;
  logic signed [SIZE_ADC_DATA-1:0] ev_amp_q, ev_amp_d;
  logic [TS_WIDTH-1:0]             ev_time_q, ev_time_d;
  logic                            ev_pileup_q, ev_pileup_d;
  logic                            filt_rst_n_q, filt_rst_n_d;
  logic                            busy_q, busy_d;

  logic                            above;
  logic                            rising;
  logic                            upd;
  logic signed [SIZE_ADC_DATA-1:0] pk_nxt;
  logic [TS_WIDTH-1:0]             pkt_nxt;
  logic                            below_nxt;
  logic                            pile_nxt;

  always_comb begin
    above  = filt_data > threshold;
    rising = above && !prev_above_q;

    // Strict compare keeps the earliest sample of a plateau.
    upd       = filt_data > peak_q;
    pk_nxt    = upd ? filt_data : peak_q;
    pkt_nxt   = upd ? ts : peak_time_q;
    below_nxt = below_q || !above;
    pile_nxt  = pileup_q || (above && below_q);

    state_d      = state_q;
    cnt_d        = cnt_q;
    peak_d       = peak_q;
    peak_time_d  = peak_time_q;
    below_d      = below_q;
    pileup_d     = pileup_q;
    prev_above_d = above;
    drop_cnt_d   = drop_cnt_q;
    ev_valid_d   = ev_valid_q;
    ev_amp_d     = ev_amp_q;
    ev_time_d    = ev_time_q;
    ev_pileup_d  = ev_pileup_q;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (!enable)          state_d = IDLE;
        else if (cnt_q == '0) state_d = ARMED;
        else                  cnt_d   = cnt_q - CNT_W'(1);
      end
      ARMED: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (above) begin
          state_d     = PEAK;
          peak_d      = filt_data;
          peak_time_d = ts;
          cnt_d       = CNT_W'(PEAK_WINDOW - 2);
          below_d     = 1'b0;
          pileup_d    = 1'b0;
        end
      end
      PEAK: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          peak_d      = pk_nxt;
          peak_time_d = pkt_nxt;
          below_d     = below_nxt;
          pileup_d    = pile_nxt;
          if (cnt_q == '0) begin
            state_d     = REPORT;
            ev_valid_d  = 1'b1;
            ev_amp_d    = pk_nxt;
            ev_time_d   = pkt_nxt;
            ev_pileup_d = pile_nxt;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      REPORT: begin
        if (ev_ready) begin
          state_d    = HOLDOFF;
          ev_valid_d = 1'b0;
          cnt_d      = CNT_W'(HOLDOFF_CYCLES - 1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) state_d = enable ? ARMED : IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == REPORT || state_q == HOLDOFF) && rising && drop_cnt_q != 8'hFF)
      drop_cnt_d = drop_cnt_q + 8'd1;

    filt_rst_n_d = (state_d != IDLE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      peak_q       <= '0;
      peak_time_q  <= '0;
      below_q      <= 1'b0;
      pileup_q     <= 1'b0;
      prev_above_q <= 1'b0;
      drop_cnt_q   <= '0;
      ev_valid_q   <= 1'b0;
      ev_amp_q     <= '0;
      ev_time_q    <= '0;
      ev_pileup_q  <= 1'b0;
      filt_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      peak_q       <= peak_d;
      peak_time_q  <= peak_time_d;
      below_q      <= below_d;
      pileup_q     <= pileup_d;
      prev_above_q <= prev_above_d;
      drop_cnt_q   <= drop_cnt_d;
      ev_valid_q   <= ev_valid_d;
      ev_amp_q     <= ev_amp_d;
      ev_time_q    <= ev_time_d;
      ev_pileup_q  <= ev_pileup_d;
      filt_rst_n_q <= filt_rst_n_d;
      busy_q       <= busy_d;
    end
  end

  assign filt_rst_n = filt_rst_n_q;
  assign ev_valid   = ev_valid_q;
  assign ev_amp     = ev_amp_q;
  assign ev_time    = ev_time_q;
  assign ev_pileup  = ev_pileup_q;
  assign drop_cnt   = drop_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_trap_event_ctrl.sv
// Scoreboard bench for trap_event_ctrl: directed pulses push expected events,
// a negedge monitor compares every cycle ev_valid is presented.
module tb_trap_event_ctrl;
  import package_settings_v2::*;

  localparam int TS_W = 8;

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b0;
  logic                            enable = 1'b0;
  logic signed [SIZE_ADC_DATA-1:0] threshold = 16'sd100;
  logic signed [SIZE_ADC_DATA-1:0] filt_data = '0;
  logic                            filt_rst_n;
  logic                            ev_valid;
  logic                            ev_ready = 1'b1;
  logic signed [SIZE_ADC_DATA-1:0] ev_amp;
  logic [TS_W-1:0]                 ev_time;
  logic                            ev_pileup;
  logic [7:0]                      drop_cnt;
  logic                            busy;

  trap_event_ctrl #(
    .SETTLE_CYCLES  (32),
    .PEAK_WINDOW    (16),
    .HOLDOFF_CYCLES (8),
    .TS_WIDTH       (TS_W)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .enable     (enable),
    .threshold  (threshold),
    .filt_data  (filt_data),
    .filt_rst_n (filt_rst_n),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_amp     (ev_amp),
    .ev_time    (ev_time),
    .ev_pileup  (ev_pileup),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [SIZE_ADC_DATA-1:0] amp;
    logic [TS_W-1:0]                 t;
    logic                            pile;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // Reference timestamp: the value the DUT counter holds in the current cycle.
  logic [TS_W-1:0] ts_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_m <= '0;
    else        ts_m <= ts_m + 8'd1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ev_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got amp=%0d time=%0d pileup=%0d expected none",
                 ev_amp, ev_time, ev_pileup);
      end else begin
        check("ev_amp", ev_amp, $signed(exp_q[0].amp));
        check("ev_time", ev_time, exp_q[0].t);
        check("ev_pileup", ev_pileup, exp_q[0].pile);
        if (ev_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d);
    filt_data = SIZE_ADC_DATA'(d);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0);
  endtask

  task automatic push(input int amp, input logic [TS_W-1:0] t, input logic pile);
    ev_t e;
    e.amp  = SIZE_ADC_DATA'(amp);
    e.t    = t;
    e.pile = pile;
    exp_q.push_back(e);
  endtask

  logic [TS_W-1:0] t_pk;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_filt_rst_n", filt_rst_n, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_ev_amp", ev_amp, 0);
    check("rst_ev_time", ev_time, 0);
    check("rst_ev_pileup", ev_pileup, 0);
    rst_n = 1'b1;
    tick();

    // Enable: filter reset released on the enable edge, quiet input
    enable = 1'b1;
    tick();
    check("en_filt_rst_n", filt_rst_n, 1);
    check("en_busy", busy, 1);
    idle(40);
    check("quiet_busy", busy, 1);
    check("quiet_ev_valid", ev_valid, 0);

    // Single pulse
    drive(0); drive(50); drive(150);
    t_pk = ts_m;
    drive(300);
    push(300, t_pk, 1'b0);
    drive(280); drive(120); drive(0);
    idle(30);
    check("single_drop_cnt", drop_cnt, 0);

    // Two pulses in one window with a dip below threshold
    drive(0); drive(150); drive(300); drive(150); drive(50); drive(200);
    t_pk = ts_m;
    drive(400);
    push(400, t_pk, 1'b1);
    drive(200);
    idle(30);

    // Consumer stalled while three further crossings arrive
    ev_ready = 1'b0;
    drive(200);
    t_pk = ts_m;
    drive(250);
    push(250, t_pk, 1'b0);
    idle(14);
    drive(150); drive(0); drive(150); drive(0); drive(150); drive(0);
    idle(14);
    check("stall_ev_valid", ev_valid, 1);
    ev_ready = 1'b1;
    drive(0);
    check("xfer_ev_valid", ev_valid, 0);
    check("stall_drop_cnt", drop_cnt, 3);
    idle(20);

    // enable dropped mid-PEAK: partial event discarded
    drive(300); drive(250); drive(200);
    enable = 1'b0;
    drive(0);
    check("abort_busy", busy, 0);
    check("abort_filt_rst_n", filt_rst_n, 0);
    idle(3);
    check("idle_filt_rst_n", filt_rst_n, 0);
    enable = 1'b1;
    tick();
    check("reen_filt_rst_n", filt_rst_n, 1);
    idle(31);
    drive(300);
    t_pk = ts_m;
    drive(200);
    push(200, t_pk, 1'b0);
    idle(30);

    // Plateau across the timestamp wrap: first of the equal maxima sits at ts 0
    for (int i = 0; i < 300 && ts_m != 8'd253; i++) drive(0);
    drive(0); drive(150); drive(200);
    push(300, 8'd0, 1'b0);
    drive(300); drive(300); drive(100);
    idle(40);

    check("events_outstanding", exp_q.size(), 0);
    check("final_drop_cnt", drop_cnt, 3);
    check("final_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_event_ctrl.md
# trap_event_ctrl

Sequencing and event-capture controller for the trapezoidal shaping filter. It drives the filter's reset, waits out the filter's settle time, then arms a threshold trigger on the filter output. On each trigger it searches a fixed window for the pulse peak and flags pile-up. It delivers amplitude and timestamp to the readout logic over a valid/ready handshake, then applies a dead-time holdoff.

## Interface
Parameters:
- SETTLE_CYCLES, 32: cycles after filter reset release before arming; must be at least the filter's L+K.
- PEAK_WINDOW, 16: samples, including the crossing sample, searched for the peak; minimum 2.
- HOLDOFF_CYCLES, 8: dead time after each accepted event; minimum 1.
- TS_WIDTH, 32: timestamp width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request.
- threshold  in  SIZE_ADC_DATA  signed trigger level; quasi-static.
- filt_data  in  SIZE_ADC_DATA  signed filter output, one sample per clk.
- filt_rst_n  out  1  active-low reset to the filter.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event.
- ev_amp  out  SIZE_ADC_DATA  signed peak value.
- ev_time  out  TS_WIDTH  timestamp of the peak sample.
- ev_pileup  out  1  second crossing seen inside the window.
- drop_cnt  out  8  saturating count of crossings lost in REPORT or HOLDOFF.
- busy  out  1  state is not IDLE.

## Operation
- Timestamp counter: free-running from reset, +1 per clk, wraps modulo 2^TS_WIDTH, independent of enable.
- Comparisons are signed, two's complement. A crossing is filt_data > threshold (strict).
- FSM states:
  - IDLE: filt_rst_n=0. Goes to SETTLE when enable=1.
  - SETTLE: filt_rst_n=1. Counts SETTLE_CYCLES, then goes to ARMED.
  - ARMED: on a crossing, goes to PEAK. Captures peak=filt_data and peak_time=current timestamp, sets window count to 1, clears pile-up.
  - PEAK: each sample with filt_data > peak updates peak and peak_time. Ties keep the earliest sample. A sample ≤ threshold sets a "below" flag. A crossing while "below" is set sets pile-up. After PEAK_WINDOW samples, goes to REPORT.
  - REPORT: ev_valid=1. ev_amp, ev_time and ev_pileup stay stable until ev_valid&ev_ready. Then goes to HOLDOFF.
  - HOLDOFF: counts HOLDOFF_CYCLES, then goes to ARMED if enable=1, else to IDLE.
- Dropped crossings: a rising crossing (previous sample ≤ threshold, current > threshold) during REPORT or HOLDOFF increments drop_cnt. drop_cnt saturates at 255 and clears only on reset.
- enable=0:
  - In SETTLE, ARMED or PEAK: goes to IDLE next edge. A partial event is discarded.
  - In REPORT: the handshake completes first. After HOLDOFF the FSM goes to IDLE.
- Re-entering SETTLE from IDLE always re-resets the filter, because at least one IDLE cycle holds filt_rst_n=0.

## Timing
- Reset values: filt_rst_n=0, ev_valid=0, ev_amp=0, ev_time=0, ev_pileup=0, drop_cnt=0, busy=0, timestamp=0, state=IDLE.
- enable sampled high at edge e: filt_rst_n=1 and busy=1 from edge e. ARMED from edge e+SETTLE_CYCLES.
- Crossing sample at edge t: samples at edges t through t+PEAK_WINDOW-1 are evaluated. ev_valid and ev_* are registered at edge t+PEAK_WINDOW-1, including the last sample, and are visible from the following cycle.
- With ev_ready held high, the transfer occurs on the first edge ev_valid is high; ev_valid drops on that edge.
- After the transfer edge h, crossings are ignored through edge h+HOLDOFF_CYCLES; the first crossing that can trigger is at edge h+HOLDOFF_CYCLES+1.
- All outputs are registered; no combinational path from inputs to outputs.
- Asynchronous reset mid-event clears the FSM to IDLE immediately. The event is lost and drop_cnt is not incremented.

## Structure
- package_settings_v2 gains:
  - ctrl_state_t enum: IDLE, SETTLE, ARMED, PEAK, REPORT, HOLDOFF.
  - Default constants for SETTLE_CYCLES, PEAK_WINDOW and HOLDOFF_CYCLES.
  - SIZE_ADC_DATA stays there.
- One sub-module: timestamp_cnt (parameter TS_WIDTH; ports clk, reset, ts).
- A single shared down-counter serves SETTLE, PEAK and HOLDOFF.

## Test plan
All scenarios use SETTLE_CYCLES=32, PEAK_WINDOW=16, HOLDOFF_CYCLES=8, threshold=100.
- Reset, then enable=1, filt_data=0 -> filt_rst_n rises on the enable edge; 40 cycles with no ev_valid; busy=1.
- Single pulse ramp 0, 50, 150, 300, 280, 120, 0 (peak at timestamp T) with ev_ready=1 -> one event: ev_amp=300, ev_time=T, ev_pileup=0, ev_valid high exactly one cycle.
- Two pulses inside one window, with a dip to 50 between peaks of 300 and 400 -> ev_amp=400, ev_pileup=1.
- ev_ready held low for 20 cycles while 3 further crossings occur -> ev_* stable throughout; drop_cnt=3 after the transfer.
- enable dropped mid-PEAK -> no event; IDLE next edge; filt_rst_n=0. Re-enable -> full SETTLE of 32 cycles before any event.
- Plateau of equal maxima 300, 300 -> ev_time equals the first 300 sample; timestamp wrap from 2^32-1 to 0 reported correctly.
